// File: rtl/execute.sv
// -----------------------------------------------------------------------------
// execute_pkg / execute
//
// Execute stage of the RV32IM pipeline. Computes single-cycle ALU and multiply
// results and runs a 32-step restoring divider for DIV/DIVU/REM/REMU. While a
// divide is in flight, decode is stalled and bubbles are sent downstream.
// All outputs to the memory stage are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   id_to_ex   instruction bundle from decode (id_to_ex_t)
//   ex_flush   kill the instruction in EX, including an in-flight divide
//   ex_stall   decode must hold id_to_ex while high (combinational)
//   ex_to_mem  registered result bundle for the memory stage (ex_to_mem_t)
// -----------------------------------------------------------------------------
package execute_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
  } ex_to_mem_t;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

endpackage

module execute
  import execute_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  id_to_ex_t  id_to_ex,
  input  logic       ex_flush,
  output logic       ex_stall,
  output ex_to_mem_t ex_to_mem
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;      // partial remainder
  logic [XLEN-1:0]   quot_q, quot_d;    // dividend shifts out, quotient shifts in
  logic [XLEN-1:0]   dvsr_q, dvsr_d;    // |divisor|
  logic [XLEN-1:0]   a_raw_q, a_raw_d;  // original dividend, for divide-by-zero remainder
  logic [XLEN-1:0]   md_q, md_d;        // rs2_val carried to mem_data
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic              want_rem_q, want_rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  ex_to_mem_t        ex_q, ex_d;

  // Operand and ALU signals
  logic [XLEN-1:0]   op_a, op_b;
  logic [4:0]        shamt;
  logic [4:0]        op;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0]   alu_res;
  logic              is_div, div_signed, want_rem;
  logic [XLEN-1:0]   a_abs, b_abs;

  // Divider step / result signals
  logic [XLEN:0]     rem_shift, diff;
  logic [XLEN-1:0]   q_fix, r_fix, div_res;

  always_comb begin
    op_a  = id_to_ex.rs1_val;
    op_b  = id_to_ex.use_imm ? id_to_ex.imm : id_to_ex.rs2_val;
    op    = id_to_ex.alu_op;
    shamt = op_b[4:0];

    // One 64-bit multiplier; the extension of each operand selects the
    // signedness. MUL only uses the low half, where extension is irrelevant.
    a_ext = {((op == OP_MULH) || (op == OP_MULHSU)) ? {XLEN{op_a[XLEN-1]}} : {XLEN{1'b0}}, op_a};
    b_ext = {(op == OP_MULH) ? {XLEN{op_b[XLEN-1]}} : {XLEN{1'b0}}, op_b};
    prod  = a_ext * b_ext;

    is_div     = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    div_signed = (op == OP_DIV) || (op == OP_REM);
    want_rem   = (op == OP_REM) || (op == OP_REMU);
    a_abs      = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
    b_abs      = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

    alu_res = '0;
    case (op)
      OP_ADD:    alu_res = op_a + op_b;
      OP_SUB:    alu_res = op_a - op_b;
      OP_SLL:    alu_res = op_a << shamt;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_SRL:    alu_res = op_a >> shamt;
      OP_SRA:    alu_res = $signed(op_a) >>> shamt;
      OP_OR:     alu_res = op_a | op_b;
      OP_AND:    alu_res = op_a & op_b;
      OP_PASSB:  alu_res = op_b;
      OP_MUL:    alu_res = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      default:   alu_res = '0;
    endcase
  end

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the difference only if it did not go negative (MSB of the 33-bit diff).
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
  end

  // Sign correction and special cases for the value registered in DONE.
  always_comb begin
    q_fix = q_neg_q ? -quot_q : quot_q;
    r_fix = r_neg_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_raw_q;
    end else if (ovf_q) begin
      q_fix = {1'b1, {(XLEN-1){1'b0}}};
      r_fix = '0;
    end
    div_res = want_rem_q ? r_fix : q_fix;
  end

  assign ex_stall = ((state_q == S_IDLE) && id_to_ex.valid && is_div && !ex_flush) ||
                    (state_q == S_BUSY);

  // Next-state, divider datapath and output register contents.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    a_raw_d    = a_raw_q;
    md_d       = md_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    mr_d       = mr_q;
    mw_d       = mw_q;
    want_rem_d = want_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div0_d     = div0_q;
    ovf_d      = ovf_q;
    ex_d       = '0;  // bubble unless something below produces a result

    case (state_q)
      S_IDLE: begin
        if (id_to_ex.valid && !is_div) begin
          ex_d.alu_result = alu_res;
          ex_d.mem_data   = id_to_ex.rs2_val;
          ex_d.mem_read   = id_to_ex.mem_read;
          ex_d.mem_write  = id_to_ex.mem_write;
          ex_d.reg_write  = id_to_ex.reg_write;
          ex_d.rd         = id_to_ex.rd;
        end else if (id_to_ex.valid && is_div) begin
          state_d    = S_BUSY;
          cnt_d      = CW'(DIV_STEPS);
          rem_d      = '0;
          quot_d     = a_abs;
          dvsr_d     = b_abs;
          a_raw_d    = op_a;
          md_d       = id_to_ex.rs2_val;
          rd_d       = id_to_ex.rd;
          rw_d       = id_to_ex.reg_write;
          mr_d       = id_to_ex.mem_read;
          mw_d       = id_to_ex.mem_write;
          want_rem_d = want_rem;
          q_neg_d    = div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
          r_neg_d    = div_signed && op_a[XLEN-1];
          div0_d     = (op_b == '0);
          ovf_d      = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        end
      end
      S_BUSY: begin
        if (!diff[XLEN]) begin
          rem_d  = diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d         = S_IDLE;
        ex_d.alu_result = div_res;
        ex_d.mem_data   = md_q;
        ex_d.mem_read   = mr_q;
        ex_d.mem_write  = mw_q;
        ex_d.reg_write  = rw_q;
        ex_d.rd         = rd_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: bubble out, divider abandoned.
    if (ex_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ex_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      a_raw_q    <= '0;
      md_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      want_rem_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ex_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      a_raw_q    <= a_raw_d;
      md_q       <= md_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      mr_q       <= mr_d;
      mw_q       <= mw_d;
      want_rem_q <= want_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div0_q     <= div0_d;
      ovf_q      <= ovf_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_to_mem = ex_q;

endmodule
